// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM state encoding, mode-0 constants and a sizing helper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam logic SPI_MSB_FIRST = 1'b1;

    // Largest of three delay settings, used to size the shared delay counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// Half-period counter for the SPI clock: owns the sck register and emits
// one-cycle strobes on the cycle that sck is about to rise or fall.
module spi_master_clkgen
    import spi_pkg::*;
#(
    parameter int unsigned CLKS_PER_HALF_BIT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise_tick_c,
    output logic o_fall_tick_c
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_HALF_BIT - 1);

    logic [CNT_W-1:0] r_half_cnt;
    logic             r_sck;
    logic             w_wrap;

    assign w_wrap        = i_en && (r_half_cnt == CNT_LAST);
    assign o_rise_tick_c = w_wrap && !r_sck;
    assign o_fall_tick_c = w_wrap && r_sck;
    assign o_sck         = r_sck;

    // Disabled means parked: counter cleared and sck at its idle level, so each
    // enable starts with a full low phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_half_cnt <= '0;
            r_sck      <= SPI_CPOL;
        end else if (!i_en) begin
            r_half_cnt <= '0;
            r_sck      <= SPI_CPOL;
        end else if (w_wrap) begin
            r_half_cnt <= '0;
            r_sck      <= ~r_sck;
        end else begin
            r_half_cnt <= r_half_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: byte-level valid/ready front end, one ss frame per burst,
// MSB-first shifting on mosi with parallel capture of miso.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned CLKS_PER_HALF_BIT = 4,
    parameter int unsigned CS_SETUP_CLKS     = 4,
    parameter int unsigned CS_HOLD_CLKS      = 4,
    parameter int unsigned CS_IDLE_CLKS      = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    input  logic [7:0] i_tx_byte,
    input  logic       i_tx_last,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_sck,
    output logic       o_mosi,
    input  logic       i_miso,
    output logic       o_ss
);

    localparam int unsigned DLY_MAX = max3(CS_SETUP_CLKS, CS_HOLD_CLKS + 1, CS_IDLE_CLKS);
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

    localparam logic [DLY_W-1:0] SETUP_LAST = DLY_W'(CS_SETUP_CLKS - 1);
    localparam logic [DLY_W-1:0] HOLD_LAST  = DLY_W'(CS_HOLD_CLKS);
    localparam logic [DLY_W-1:0] GAP_LAST   = DLY_W'(CS_IDLE_CLKS - 1);

    state_t           r_state;
    logic [DLY_W-1:0] r_dly;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_tx_shift;
    logic [7:0]       r_rx_shift;
    logic             r_last;
    logic             r_mosi;
    logic             r_ss;
    logic             r_tx_ready;
    logic             r_rx_valid;
    logic [7:0]       r_rx_byte;
    logic             r_miso_meta;
    logic             r_miso_sync;

    logic             w_shift_en;
    logic             w_rise;
    logic             w_fall;
    logic             w_accept;

    assign w_shift_en = (r_state == ST_SHIFT);
    assign w_accept   = i_tx_valid && r_tx_ready;

    spi_master_clkgen #(
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_clkgen (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (w_shift_en),
        .o_sck         (o_sck),
        .o_rise_tick_c (w_rise),
        .o_fall_tick_c (w_fall)
    );

    // Two-flop synchronizer; only r_miso_sync is ever used downstream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= i_miso;
            r_miso_sync <= r_miso_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_dly      <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_last     <= 1'b0;
            r_mosi     <= 1'b0;
            r_ss       <= 1'b1;
            r_tx_ready <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_byte  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_tx_shift <= {i_tx_byte[6:0], 1'b0};
                        r_mosi     <= i_tx_byte[7];
                        r_last     <= i_tx_last;
                        r_ss       <= 1'b0;
                        r_tx_ready <= 1'b0;
                        r_dly      <= '0;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_dly == SETUP_LAST) begin
                        r_dly     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHIFT;
                    end else begin
                        r_dly <= r_dly + DLY_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        r_rx_shift <= {r_rx_shift[6:0], r_miso_sync};
                    end
                    if (w_fall) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_byte  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                            r_dly      <= '0;
                            if (r_last) begin
                                r_state <= ST_HOLD;
                            end else begin
                                r_tx_ready <= 1'b1;
                                r_state    <= ST_WAIT;
                            end
                        end else begin
                            r_mosi     <= r_tx_shift[7];
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_accept) begin
                        r_tx_shift <= {i_tx_byte[6:0], 1'b0};
                        r_mosi     <= i_tx_byte[7];
                        r_last     <= i_tx_last;
                        r_tx_ready <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_state    <= ST_SHIFT;
                    end
                end
                // Hold also covers the rx_valid cycle, so ss stays low one cycle past CS_HOLD_CLKS.
                ST_HOLD: begin
                    if (r_dly == HOLD_LAST) begin
                        r_ss    <= 1'b1;
                        r_dly   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_dly <= r_dly + DLY_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_dly == GAP_LAST) begin
                        r_dly      <= '0;
                        r_tx_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_dly <= r_dly + DLY_W'(1);
                    end
                end
                default: begin
                    r_ss       <= 1'b1;
                    r_tx_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_ready = r_tx_ready;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_byte  = r_rx_byte;
    assign o_mosi     = r_mosi;
    assign o_ss       = r_ss;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: table of single-byte transfers against either a
// mosi loopback or a small mode-0 slave model, plus hand-written burst/stall/reset cases.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_last;
    logic       miso;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       sck;
    logic       mosi;
    logic       ss;

    int checks   = 0;
    int failures = 0;

    spi_master #(
        .CLKS_PER_HALF_BIT(4),
        .CS_SETUP_CLKS    (4),
        .CS_HOLD_CLKS     (4),
        .CS_IDLE_CLKS     (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_tx_valid (tx_valid),
        .o_tx_ready (tx_ready),
        .i_tx_byte  (tx_byte),
        .i_tx_last  (tx_last),
        .o_rx_valid (rx_valid),
        .o_rx_byte  (rx_byte),
        .o_sck      (sck),
        .o_mosi     (mosi),
        .i_miso     (miso),
        .o_ss       (ss)
    );

    always #10 clk = ~clk;

    // Mode-0 slave model: shifts on sck falling, captures mosi on sck rising.
    logic       loop_en = 1'b1;
    logic [7:0] s_pre   = 8'h00;
    logic [7:0] s_rx    = 8'h00;
    int         s_fall  = 0;
    logic       s_miso;

    always @(negedge sck or posedge ss) begin
        if (ss) s_fall <= 0;
        else    s_fall <= s_fall + 1;
    end
    always @(posedge sck) s_rx <= {s_rx[6:0], mosi};
    assign s_miso = (s_fall < 8) ? s_pre[3'(7 - s_fall)] : 1'b0;
    assign miso   = loop_en ? mosi : s_miso;

    // Monitors
    int         cyc      = 0;
    int         rise_cnt = 0;
    int         rxv_cnt  = 0;
    int         ss_low   = 0;
    int         ss_rise  = 0;
    logic [7:0] rxq[$];
    int         rxt[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge sck) rise_cnt <= rise_cnt + 1;
    always @(posedge ss)  ss_rise  <= ss_rise + 1;
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rxv_cnt <= rxv_cnt + 1;
            rxq.push_back(rx_byte);
            rxt.push_back(cyc);
        end
        if (ss === 1'b0) ss_low <= ss_low + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Presents a byte and waits (bounded) until it is accepted; returns at the negedge after the accept.
    task automatic push(input logic [7:0] b, input logic l, output int waited);
        tx_byte  = b;
        tx_last  = l;
        tx_valid = 1'b1;
        waited   = 0;
        while (!tx_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        chk("push_ready", 32'(tx_ready), 1);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ss && tx_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(ss && tx_ready), 1);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic       loop;
        logic [7:0] spre;
        logic [7:0] exp_rx;
        logic [7:0] exp_srx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int w, n, g, r0, v0, l0, s0, q0;
        int bad_ss, bad_sck, bad_rdy;

        vecs[0] = '{tx: 8'hA5, loop: 1'b1, spre: 8'h00, exp_rx: 8'hA5, exp_srx: 8'hA5};
        vecs[1] = '{tx: 8'h3C, loop: 1'b0, spre: 8'h5A, exp_rx: 8'h5A, exp_srx: 8'h3C};
        vecs[2] = '{tx: 8'h00, loop: 1'b1, spre: 8'h00, exp_rx: 8'h00, exp_srx: 8'h00};
        vecs[3] = '{tx: 8'hFF, loop: 1'b1, spre: 8'h00, exp_rx: 8'hFF, exp_srx: 8'hFF};
        vecs[4] = '{tx: 8'h81, loop: 1'b0, spre: 8'h7E, exp_rx: 8'h7E, exp_srx: 8'h81};

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        tx_last  = 1'b0;
        #35;
        chk("rst_ss", 32'(ss), 1);
        chk("rst_sck", 32'(sck), 0);
        chk("rst_mosi", 32'(mosi), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_byte", 32'(rx_byte), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-byte transfers with tx_last=1.
        for (int i = 0; i < 5; i++) begin
            loop_en = vecs[i].loop;
            s_pre   = vecs[i].spre;
            wait_idle();
            r0 = rise_cnt; v0 = rxv_cnt; l0 = ss_low;
            tx_byte  = vecs[i].tx;
            tx_last  = 1'b1;
            tx_valid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1) tx_valid = 1'b0;
            end while (!sck && n < 200);
            chk($sformatf("v%0d_first_rise_lat", i), n, 9);
            n = 0;
            while (!ss && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("v%0d_ss_released", i), 32'(ss), 1);
            g = 0;
            while (!tx_ready && g < 100) begin
                g++;
                @(negedge clk);
            end
            chk($sformatf("v%0d_gap_clks", i), g, 4);
            chk($sformatf("v%0d_rx_byte", i), 32'(rx_byte), 32'(vecs[i].exp_rx));
            chk($sformatf("v%0d_slave_rx", i), 32'(s_rx), 32'(vecs[i].exp_srx));
            chk($sformatf("v%0d_rises", i), rise_cnt - r0, 8);
            chk($sformatf("v%0d_rx_valids", i), rxv_cnt - v0, 1);
            chk($sformatf("v%0d_ss_low_clks", i), ss_low - l0, 73);
        end

        // Back-to-back burst 0x01,0x02,0x03 under one ss frame.
        loop_en = 1'b1;
        r0 = rise_cnt; v0 = rxv_cnt; s0 = ss_rise; q0 = rxq.size();
        push(8'h01, 1'b0, w);
        push(8'h02, 1'b0, w);
        push(8'h03, 1'b1, w);
        tx_valid = 1'b0;
        wait_idle();
        chk("burst_rises", rise_cnt - r0, 24);
        chk("burst_rx_valids", rxv_cnt - v0, 3);
        chk("burst_ss_rises", ss_rise - s0, 1);
        if (rxq.size() >= q0 + 3) begin
            chk("burst_b0", 32'(rxq[q0]), 32'h01);
            chk("burst_b1", 32'(rxq[q0+1]), 32'h02);
            chk("burst_b2", 32'(rxq[q0+2]), 32'h03);
            chk("burst_gap01", rxt[q0+1] - rxt[q0], 65);
            chk("burst_gap12", rxt[q0+2] - rxt[q0+1], 65);
        end

        // Stall inside a burst: 20 idle cycles in WAIT.
        v0 = rxv_cnt; s0 = ss_rise; q0 = rxq.size();
        push(8'h11, 1'b0, w);
        tx_valid = 1'b0;
        n = 0;
        while (!rx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_first_done", 32'(rx_valid), 1);
        bad_ss = 0; bad_sck = 0; bad_rdy = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ss !== 1'b0)       bad_ss++;
            if (sck !== 1'b0)      bad_sck++;
            if (tx_ready !== 1'b1) bad_rdy++;
        end
        chk("stall_ss_high_clks", bad_ss, 0);
        chk("stall_sck_high_clks", bad_sck, 0);
        chk("stall_not_ready_clks", bad_rdy, 0);
        push(8'h22, 1'b1, w);
        chk("stall_accept_wait", w, 0);
        tx_valid = 1'b0;
        wait_idle();
        chk("stall_rx_valids", rxv_cnt - v0, 2);
        chk("stall_ss_rises", ss_rise - s0, 1);
        if (rxq.size() >= q0 + 2) begin
            chk("stall_b0", 32'(rxq[q0]), 32'h11);
            chk("stall_b1", 32'(rxq[q0+1]), 32'h22);
        end

        // Reset after the third rising edge.
        r0 = rise_cnt; v0 = rxv_cnt;
        push(8'hC3, 1'b1, w);
        tx_valid = 1'b0;
        n = 0;
        while ((rise_cnt - r0) < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_third_rise", rise_cnt - r0, 3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ss", 32'(ss), 1);
        chk("rst_mid_sck", 32'(sck), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(tx_ready), 1);
        chk("rst_mid_no_rx_valid", rxv_cnt - v0, 0);
        v0 = rxv_cnt;
        push(8'hFF, 1'b1, w);
        tx_valid = 1'b0;
        wait_idle();
        chk("rst_after_rx_valids", rxv_cnt - v0, 1);
        chk("rst_after_rx_byte", 32'(rx_byte), 32'hFF);

        // 0x77 held during SETUP/SHIFT is only taken once WAIT is reached.
        v0 = rxv_cnt; q0 = rxq.size();
        push(8'h10, 1'b0, w);
        push(8'h77, 1'b1, w);
        chk("hold77_wait_clks", w, 68);
        tx_valid = 1'b0;
        wait_idle();
        chk("hold77_rx_valids", rxv_cnt - v0, 2);
        if (rxq.size() >= q0 + 2) begin
            chk("hold77_b0", 32'(rxq[q0]), 32'h10);
            chk("hold77_b1", 32'(rxq[q0+1]), 32'h77);
            chk("hold77_gap", rxt[q0+1] - rxt[q0], 65);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400us;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
